// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/LSU requesters, the memory port arbiter and the core memory.
// slave = arbiter view, master = environment view (requesters plus memory).
interface mem_port_arbiter_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 10
);
    logic              if_req_valid_i;
    logic              if_req_ready_o;
    logic [XLEN-1:0]   if_addr_i;
    logic              if_rsp_valid_o;
    logic [XLEN-1:0]   if_rdata_o;

    logic              lsu_req_valid_i;
    logic              lsu_req_ready_o;
    logic              lsu_we_i;
    logic [3:0]        lsu_be_i;
    logic [XLEN-1:0]   lsu_addr_i;
    logic [XLEN-1:0]   lsu_wdata_i;
    logic              lsu_rsp_valid_o;
    logic [XLEN-1:0]   lsu_rdata_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [3:0]        mem_be_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [XLEN-1:0]   mem_wdata_o;
    logic [XLEN-1:0]   mem_rdata_i;

    modport slave (
        input  if_req_valid_i, if_addr_i,
        input  lsu_req_valid_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i,
        input  mem_rdata_i,
        output if_req_ready_o, if_rsp_valid_o, if_rdata_o,
        output lsu_req_ready_o, lsu_rsp_valid_o, lsu_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output if_req_valid_i, if_addr_i,
        output lsu_req_valid_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i,
        output mem_rdata_i,
        input  if_req_ready_o, if_rsp_valid_o, if_rdata_o,
        input  lsu_req_ready_o, lsu_rsp_valid_o, lsu_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single-port core memory between instruction fetch and the LSU; round-robin by
// default, fixed LSU priority when MEM_ARB_LSU_PRIO_EN is defined.
module mem_port_arbiter #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 10
) (
    input logic               clk_i,
    input logic               rst_i,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RSP_IF, RSP_LSU} state_t;

    state_t state;
    logic   lsu_we_q;
    logic   grant_if;
    logic   grant_lsu;

`ifdef MEM_ARB_LSU_PRIO_EN
    assign grant_lsu = !rst_i && bus.lsu_req_valid_i;
    assign grant_if  = !rst_i && bus.if_req_valid_i && !bus.lsu_req_valid_i;
`else
    typedef enum logic {RR_IF, RR_LSU} rr_t;
    rr_t rr_last;

    // On a conflict the requester that was not served last wins.
    assign grant_if  = !rst_i && bus.if_req_valid_i
                       && (!bus.lsu_req_valid_i || rr_last == RR_LSU);
    assign grant_lsu = !rst_i && bus.lsu_req_valid_i
                       && (!bus.if_req_valid_i || rr_last == RR_IF);
`endif

    // Owner of the response returning next cycle; re-evaluated every cycle so grants pipeline.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst_i) begin
            state    <= IDLE;
            lsu_we_q <= 1'b0;
`ifndef MEM_ARB_LSU_PRIO_EN
            rr_last  <= RR_LSU;
`endif
        end else begin
            if (grant_if) begin
                state <= RSP_IF;
            end else if (grant_lsu) begin
                state <= RSP_LSU;
            end else begin
                state <= IDLE;
            end
            if (grant_lsu) begin
                lsu_we_q <= bus.lsu_we_i;
            end
`ifndef MEM_ARB_LSU_PRIO_EN
            if (grant_if) begin
                rr_last <= RR_IF;
            end else if (grant_lsu) begin
                rr_last <= RR_LSU;
            end
`endif
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        bus.if_req_ready_o  = grant_if;
        bus.lsu_req_ready_o = grant_lsu;
        bus.mem_req_o       = grant_if || grant_lsu;
        bus.mem_we_o        = 1'b0;
        bus.mem_be_o        = 4'b0000;
        bus.mem_addr_o      = '0;
        bus.mem_wdata_o     = '0;
        if (grant_if) begin
            bus.mem_addr_o = bus.if_addr_i[ADDR_W+1:2];
        end else if (grant_lsu) begin
            bus.mem_we_o    = bus.lsu_we_i;
            bus.mem_be_o    = bus.lsu_be_i;
            bus.mem_addr_o  = bus.lsu_addr_i[ADDR_W+1:2];
            bus.mem_wdata_o = bus.lsu_wdata_i;
        end
    end

    // Responses are suppressed while reset is held, which also drops a grant made just before it.
    always_comb begin
        bus.if_rsp_valid_o  = !rst_i && (state == RSP_IF);
        bus.lsu_rsp_valid_o = !rst_i && (state == RSP_LSU);
        bus.if_rdata_o      = '0;
        bus.lsu_rdata_o     = '0;
        if (bus.if_rsp_valid_o) begin
            bus.if_rdata_o = bus.mem_rdata_i;
        end
        if (bus.lsu_rsp_valid_o && !lsu_we_q) begin
            bus.lsu_rdata_o = bus.mem_rdata_i;
        end
    end

    // Byte offset and bits above the memory size are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr_i[XLEN-1:ADDR_W+2], bus.if_addr_i[1:0],
                                bus.lsu_addr_i[XLEN-1:ADDR_W+2], bus.lsu_addr_i[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected memory accesses and
// responses; a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_port_arbiter;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 10;

    typedef struct {
        logic        own_lsu;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_txn_t;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_txn_t    exp_mem[$];
    logic [31:0] exp_if[$];
    logic [31:0] exp_lsu[$];
    logic [31:0] mem [1024];

    mem_port_arbiter_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory with one-cycle read latency; read returns pre-write data.
    always @(posedge clk) begin
        if (bus.mem_req_o) begin
            bus.mem_rdata_i <= mem[bus.mem_addr_o];
            if (bus.mem_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_be_o[b]) mem[bus.mem_addr_o][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic note_unexpected(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got an unexpected output, expected none", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_if(input logic v, input logic [31:0] a);
        bus.if_req_valid_i = v;
        bus.if_addr_i      = a;
    endtask

    task automatic drive_lsu(input logic v, input logic we, input logic [3:0] be,
                             input logic [31:0] a, input logic [31:0] wd);
        bus.lsu_req_valid_i = v;
        bus.lsu_we_i        = we;
        bus.lsu_be_i        = be;
        bus.lsu_addr_i      = a;
        bus.lsu_wdata_i     = wd;
    endtask

    task automatic expect_if(input logic [31:0] word, input logic [31:0] rdata);
        mem_txn_t t;
        t.own_lsu = 1'b0; t.we = 1'b0; t.be = 4'b0000; t.addr = word; t.wdata = 32'h0;
        exp_mem.push_back(t);
        exp_if.push_back(rdata);
    endtask

    task automatic expect_lsu(input logic we, input logic [3:0] be, input logic [31:0] word,
                              input logic [31:0] wdata, input logic [31:0] rdata);
        mem_txn_t t;
        t.own_lsu = 1'b1; t.we = we; t.be = be; t.addr = word; t.wdata = wdata;
        exp_mem.push_back(t);
        exp_lsu.push_back(rdata);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ready"}, {30'd0, bus.if_req_ready_o, bus.lsu_req_ready_o}, 32'd0);
        check({tag, "_rsp_valid"}, {30'd0, bus.if_rsp_valid_o, bus.lsu_rsp_valid_o}, 32'd0);
        check({tag, "_mem_req"}, {31'd0, bus.mem_req_o}, 32'd0);
    endtask

    always @(negedge clk) begin : monitor
        mem_txn_t t;
        if (bus.mem_req_o) begin
            if (exp_mem.size() == 0) begin
                note_unexpected("mem_req");
            end else begin
                t = exp_mem.pop_front();
                check("if_req_ready", {31'd0, bus.if_req_ready_o}, {31'd0, !t.own_lsu});
                check("lsu_req_ready", {31'd0, bus.lsu_req_ready_o}, {31'd0, t.own_lsu});
                check("mem_we", {31'd0, bus.mem_we_o}, {31'd0, t.we});
                check("mem_be", {28'd0, bus.mem_be_o}, {28'd0, t.be});
                check("mem_addr", {22'd0, bus.mem_addr_o}, t.addr);
                check("mem_wdata", bus.mem_wdata_o, t.wdata);
            end
        end else begin
            check("ready_without_req", {30'd0, bus.if_req_ready_o, bus.lsu_req_ready_o}, 32'd0);
        end
        if (bus.if_rsp_valid_o) begin
            if (exp_if.size() == 0) note_unexpected("if_rsp_valid");
            else check("if_rdata", bus.if_rdata_o, exp_if.pop_front());
        end else begin
            check("if_rdata_idle", bus.if_rdata_o, 32'd0);
        end
        if (bus.lsu_rsp_valid_o) begin
            if (exp_lsu.size() == 0) note_unexpected("lsu_rsp_valid");
            else check("lsu_rdata", bus.lsu_rdata_o, exp_lsu.pop_front());
        end else begin
            check("lsu_rdata_idle", bus.lsu_rdata_o, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[1] = 32'h11111111;
        mem[2] = 32'h22222222;
        mem[3] = 32'h33333333;
        mem[4] = 32'h00500093;
        mem[5] = 32'h55555555;
        mem[6] = 32'h66666666;
        mem[8] = 32'h12345678;

        // Reset held for two edges with both requesters active.
        rst = 1'b1;
        drive_if(1'b1, 32'h10);
        drive_lsu(1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        #2 check_quiet("reset_t0");
        step(); check_quiet("reset_t1");
        step(); check_quiet("reset_t2");
        rst = 1'b0;

        // First post-reset conflict.
`ifdef MEM_ARB_LSU_PRIO_EN
        expect_lsu(1'b0, 4'hF, 32'd2, 32'h0, 32'h22222222);
        step(); drive_lsu(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        expect_if(32'd4, 32'h00500093);
`else
        expect_if(32'd4, 32'h00500093);
        step(); drive_if(1'b0, 32'h0);
        expect_lsu(1'b0, 4'hF, 32'd2, 32'h0, 32'h22222222);
`endif
        step(); drive_if(1'b0, 32'h0); drive_lsu(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Lone fetch with upper address bits and byte offset set: word 4 after truncation.
        step(); drive_if(1'b1, 32'hFFFF1013);
        expect_if(32'd4, 32'h00500093);

        // Store half-word, then read the same word back on the following cycle.
        step(); drive_if(1'b0, 32'h0);
        drive_lsu(1'b1, 1'b1, 4'b0011, 32'h20, 32'hDEADBEEF);
        expect_lsu(1'b1, 4'b0011, 32'd8, 32'hDEADBEEF, 32'h0);
        step(); drive_lsu(1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        expect_lsu(1'b0, 4'hF, 32'd8, 32'h0, 32'h1234BEEF);

        // Sustained conflict: both keep requesting, each advancing its address when accepted.
`ifdef MEM_ARB_LSU_PRIO_EN
        step(); drive_if(1'b1, 32'h4); drive_lsu(1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        expect_lsu(1'b0, 4'hF, 32'd2, 32'h0, 32'h22222222);
        step(); drive_lsu(1'b1, 1'b0, 4'hF, 32'h14, 32'h0);
        expect_lsu(1'b0, 4'hF, 32'd5, 32'h0, 32'h55555555);
        step(); drive_lsu(1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        expect_lsu(1'b0, 4'hF, 32'd8, 32'h0, 32'h1234BEEF);
        step(); drive_lsu(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        expect_if(32'd1, 32'h11111111);
`else
        step(); drive_if(1'b1, 32'h4); drive_lsu(1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        expect_if(32'd1, 32'h11111111);
        step(); drive_if(1'b1, 32'hC);
        expect_lsu(1'b0, 4'hF, 32'd2, 32'h0, 32'h22222222);
        step(); drive_lsu(1'b1, 1'b0, 4'hF, 32'h14, 32'h0);
        expect_if(32'd3, 32'h33333333);
        step(); drive_if(1'b1, 32'h18);
        expect_lsu(1'b0, 4'hF, 32'd5, 32'h0, 32'h55555555);
        step(); drive_lsu(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        expect_if(32'd6, 32'h66666666);
`endif
        step(); drive_if(1'b0, 32'h0); drive_lsu(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Reset one cycle after an IF grant: that grant must not produce a response.
        step(); drive_if(1'b1, 32'h10);
        begin
            mem_txn_t t;
            t.own_lsu = 1'b0; t.we = 1'b0; t.be = 4'b0000; t.addr = 32'd4; t.wdata = 32'h0;
            exp_mem.push_back(t);
        end
        step(); rst = 1'b1;
        drive_lsu(1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        #2 check_quiet("midreset_t1");
        step(); check_quiet("midreset_t2");
        rst = 1'b0;
`ifdef MEM_ARB_LSU_PRIO_EN
        expect_lsu(1'b0, 4'hF, 32'd2, 32'h0, 32'h22222222);
        step(); drive_lsu(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        expect_if(32'd4, 32'h00500093);
`else
        expect_if(32'd4, 32'h00500093);
        step(); drive_if(1'b0, 32'h0);
        expect_lsu(1'b0, 4'hF, 32'd2, 32'h0, 32'h22222222);
`endif
        step(); drive_if(1'b0, 32'h0); drive_lsu(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) step();

        check("exp_mem_left", exp_mem.size(), 32'd0);
        check("exp_if_left", exp_if.size(), 32'd0);
        check("exp_lsu_left", exp_lsu.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
